// File: rtl/gcd_lcm_stage_if.sv
// Handshake and data bundle between the sequencer/GCD unit
// and the LCM stage.
interface gcd_lcm_stage_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [WIDTH-1:0] x_i;
  logic [WIDTH-1:0] y_i;
  logic [WIDTH-1:0] gcd_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] lcm_o;
  logic             err_o;
  logic             ovf_o;

  modport master (
    output start_i, x_i, y_i, gcd_i,
    input  busy_o, done_o, lcm_o, err_o, ovf_o
  );

  modport slave (
    input  start_i, x_i, y_i, gcd_i,
    output busy_o, done_o, lcm_o, err_o, ovf_o
  );
endinterface

// File: rtl/gcd_lcm_stage.sv
// LCM stage: lcm = (x / gcd) * y using a restoring divider
// followed by a shift-add multiplier sharing one FSMD.
module gcd_lcm_stage #(
  parameter int WIDTH = 32
) (
  input  logic          CLK,
  input  logic          reset,
  gcd_lcm_stage_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   q;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   yr;
  logic [WIDTH-1:0]   gr;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   lcm_r;
  logic               err_r;
  logic               ovf_r;

  logic [WIDTH+1:0]   div_t;
  logic [WIDTH+1:0]   div_d;
  logic               div_ge;
  logic [WIDTH+1:0]   rem_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_nxt;

  // q doubles as the dividend shift register: dividend bits
  // leave at the top while quotient bits enter at the bottom.
  always_comb begin
    div_t   = {rem, q[WIDTH-1]};
    div_d   = div_t - {2'b00, gr};
    div_ge  = div_t >= {2'b00, gr};
    rem_nxt = div_ge ? div_d : div_t;
    q_nxt   = {q[WIDTH-2:0], div_ge};
  end

  // Right-shifting product: multiplier sits in the low half.
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]}
             + {1'b0, (prod[0] ? yr : {WIDTH{1'b0}})};
    prod_nxt = {mul_sum, prod[WIDTH-1:1]};
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
      rem   <= '0;
      yr    <= '0;
      gr    <= '0;
      prod  <= '0;
      lcm_r <= '0;
      err_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            q     <= bus.x_i;
            yr    <= bus.y_i;
            gr    <= bus.gcd_i;
            rem   <= '0;
            cnt   <= '0;
            err_r <= 1'b0;
            ovf_r <= 1'b0;
            if (bus.gcd_i == '0) begin
              lcm_r <= '0;
              err_r <= 1'b1;
              state <= DONE;
            end else begin
              state <= DIV;
            end
          end
        end
        DIV: begin
          q   <= q_nxt;
          rem <= rem_nxt[WIDTH:0];
          if (cnt == LAST) begin
            cnt <= '0;
            if (|rem_nxt) begin
              lcm_r <= '0;
              err_r <= 1'b1;
              state <= DONE;
            end else begin
              prod  <= {{WIDTH{1'b0}}, q_nxt};
              state <= MUL;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MUL: begin
          prod <= prod_nxt;
          if (cnt == LAST) begin
            cnt   <= '0;
            lcm_r <= prod_nxt[WIDTH-1:0];
            ovf_r <= |prod_nxt[2*WIDTH-1:WIDTH];
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o = (state != IDLE);
  assign bus.done_o = (state == DONE);
  assign bus.lcm_o  = lcm_r;
  assign bus.err_o  = err_r;
  assign bus.ovf_o  = ovf_r;

endmodule

// File: tb/tb_gcd_lcm_stage.sv
// Directed-vector bench for gcd_lcm_stage at WIDTH=32.
// Expected values are hand-computed.
module tb_gcd_lcm_stage;

  localparam int W = 32;

  logic CLK;
  logic reset;
  int   n_vec;
  int   n_err;

  gcd_lcm_stage_if #(.WIDTH(W)) bus ();

  gcd_lcm_stage #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; accepts on the next rising edge.
  task automatic run_job(input string tag,
                         input logic [W-1:0] x,
                         input logic [W-1:0] y,
                         input logic [W-1:0] g,
                         input int lat,
                         input int nbusy,
                         input logic [W-1:0] lcm,
                         input logic err,
                         input logic ovf,
                         input int pulse_cyc);
    int idx;
    int nb;
    bit seen;
    bus.start_i = 1'b1;
    bus.x_i     = x;
    bus.y_i     = y;
    bus.gcd_i   = g;
    @(posedge CLK);
    #1;
    bus.start_i = 1'b0;
    idx  = 0;
    nb   = 0;
    seen = 0;
    while (!seen && idx < 200) begin
      @(negedge CLK);
      idx++;
      if (pulse_cyc != 0 && idx == pulse_cyc) begin
        bus.start_i = 1'b1;
        bus.x_i     = 7;
        bus.y_i     = 7;
        bus.gcd_i   = 7;
      end else begin
        bus.start_i = 1'b0;
      end
      if (bus.busy_o) nb++;
      if (bus.done_o) seen = 1;
    end
    chk({tag, ".lat"}, seen ? 64'(idx - 1) : 64'hDEAD, 64'(lat));
    chk({tag, ".busy"}, 64'(nb), 64'(nbusy));
    chk({tag, ".lcm"}, 64'(bus.lcm_o), 64'(lcm));
    chk({tag, ".err"}, 64'(bus.err_o), 64'(err));
    chk({tag, ".ovf"}, 64'(bus.ovf_o), 64'(ovf));
    @(negedge CLK);
    chk({tag, ".pulse"}, 64'(bus.done_o), 64'd0);
    chk({tag, ".idle"}, 64'(bus.busy_o), 64'd0);
    chk({tag, ".hold"}, 64'(bus.lcm_o), 64'(lcm));
  endtask

  initial begin
    int ndone;
    n_vec = 0;
    n_err = 0;
    reset       = 1'b1;
    bus.start_i = 1'b0;
    bus.x_i     = '0;
    bus.y_i     = '0;
    bus.gcd_i   = '0;
    repeat (2) @(negedge CLK);
    chk("rst.busy", 64'(bus.busy_o), 64'd0);
    chk("rst.done", 64'(bus.done_o), 64'd0);
    chk("rst.lcm", 64'(bus.lcm_o), 64'd0);
    chk("rst.err", 64'(bus.err_o), 64'd0);
    chk("rst.ovf", 64'(bus.ovf_o), 64'd0);
    reset = 1'b0;
    @(negedge CLK);

    run_job("base", 12, 18, 6, 64, 65, 36, 0, 0, 0);
    run_job("gz", 12, 18, 0, 0, 1, 0, 1, 0, 0);
    run_job("ndiv", 12, 18, 5, 32, 33, 0, 1, 0, 0);
    run_job("big", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1,
            64, 65, 32'h0000_0002, 0, 1, 0);
    run_job("ovf2", 32'h0001_0000, 32'h0001_0000, 1,
            64, 65, 0, 0, 1, 0);
    run_job("fit", 32'h0000_FFFF, 32'h0001_0001, 1,
            64, 65, 32'hFFFF_FFFF, 0, 0, 0);
    run_job("xz", 0, 18, 6, 64, 65, 0, 0, 0, 0);
    run_job("yz", 12, 0, 6, 64, 65, 0, 0, 0, 0);
    run_job("ign", 12, 18, 6, 64, 65, 36, 0, 0, 10);
    run_job("b2b", 7, 7, 7, 64, 65, 7, 0, 0, 0);

    // Mid-operation reset aborts with no done pulse.
    bus.start_i = 1'b1;
    bus.x_i     = 12;
    bus.y_i     = 18;
    bus.gcd_i   = 6;
    @(posedge CLK);
    #1;
    bus.start_i = 1'b0;
    repeat (40) @(negedge CLK);
    reset = 1'b1;
    #1;
    chk("abort.busy", 64'(bus.busy_o), 64'd0);
    chk("abort.done", 64'(bus.done_o), 64'd0);
    chk("abort.lcm", 64'(bus.lcm_o), 64'd0);
    chk("abort.err", 64'(bus.err_o), 64'd0);
    chk("abort.ovf", 64'(bus.ovf_o), 64'd0);
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (bus.done_o || bus.busy_o) ndone++;
    end
    chk("abort.quiet", 64'(ndone), 64'd0);
    run_job("post", 4, 6, 2, 64, 65, 12, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
